// File: rtl/mult_sequencer.sv
// mult_sequencer: multi-cycle MULT/MULTU engine producing a 2*DATA_LEN product
// in hi/lo. One shared DATA_LEN-bit adder is reused for operand absolute
// values, the shift-add iterations and the final two-word negation.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      multiply request, accepted only when idle and not busy
//   is_signed  1 = MULT (two's complement), 0 = MULTU
//   op_a       multiplicand
//   op_b       multiplier
//   busy       registered, high while an operation is in flight (incl. done cycle)
//   done       registered one-cycle pulse, hi/lo valid in that cycle
//   hi, lo     registered upper/lower product words
module mult_sequencer #(
  parameter int unsigned DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                is_signed,
  input  logic [DATA_LEN-1:0] op_a,
  input  logic [DATA_LEN-1:0] op_b,
  output logic                busy,
  output logic                done,
  output logic [DATA_LEN-1:0] hi,
  output logic [DATA_LEN-1:0] lo
);

  localparam int unsigned MSB   = DATA_LEN - 1;
  localparam int unsigned CNT_W = $clog2(DATA_LEN) + 1;
  localparam int unsigned SUM_W = DATA_LEN + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ABS_A,
    S_ABS_B,
    S_RUN,
    S_NEG_LO,
    S_NEG_HI,
    S_DONE
  } state_t;

  state_t              state, state_n;
  logic [DATA_LEN-1:0] a, a_n;
  logic [DATA_LEN-1:0] hi_n, lo_n;
  logic                sgn, sgn_n;
  logic                neg, neg_n;
  logic                negc, negc_n;
  logic [CNT_W-1:0]    cnt, cnt_n;

  logic [DATA_LEN-1:0] add_x, add_y;
  logic                add_cin;
  logic [SUM_W-1:0]    add_sum;
  logic [DATA_LEN-1:0] add_s;
  logic                add_c;

  // Operand steering for the single shared adder.
  always_comb begin
    add_x   = '0;
    add_y   = '0;
    add_cin = 1'b0;
    case (state)
      S_ABS_A: begin
        add_x   = ~a;
        add_cin = 1'b1;
      end
      S_ABS_B: begin
        add_x   = ~lo;
        add_cin = 1'b1;
      end
      S_RUN: begin
        add_x = hi;
        add_y = lo[0] ? a : '0;
      end
      S_NEG_LO: begin
        add_x   = ~lo;
        add_cin = 1'b1;
      end
      S_NEG_HI: begin
        add_x   = ~hi;
        add_cin = negc;
      end
      default: ;
    endcase
  end

  assign add_sum = {1'b0, add_x} + {1'b0, add_y} + SUM_W'(add_cin);
  assign add_s   = add_sum[DATA_LEN-1:0];
  assign add_c   = add_sum[DATA_LEN];

  // Next-state and datapath update.
  always_comb begin
    state_n = state;
    a_n     = a;
    hi_n    = hi;
    lo_n    = lo;
    sgn_n   = sgn;
    neg_n   = neg;
    negc_n  = negc;
    cnt_n   = cnt;
    case (state)
      S_IDLE: begin
        // busy is still high during the done cycle; starts there are dropped.
        if (start && !busy) begin
          a_n     = op_a;
          lo_n    = op_b;
          hi_n    = '0;
          sgn_n   = is_signed;
          neg_n   = is_signed & (op_a[MSB] ^ op_b[MSB]);
          cnt_n   = '0;
          state_n = is_signed ? S_ABS_A : S_RUN;
        end
      end
      S_ABS_A: begin
        if (a[MSB]) a_n = add_s;
        state_n = S_ABS_B;
      end
      S_ABS_B: begin
        if (lo[MSB]) lo_n = add_s;
        state_n = S_RUN;
      end
      S_RUN: begin
        // {hi, lo} <= {carry, sum, lo} >> 1
        hi_n  = {add_c, add_s[DATA_LEN-1:1]};
        lo_n  = {add_s[0], lo[DATA_LEN-1:1]};
        cnt_n = cnt + CNT_W'(1);
        if (cnt == CNT_LAST) state_n = sgn ? S_NEG_LO : S_DONE;
      end
      S_NEG_LO: begin
        if (neg) begin
          lo_n   = add_s;
          negc_n = add_c;
        end else begin
          negc_n = 1'b0;
        end
        state_n = S_NEG_HI;
      end
      S_NEG_HI: begin
        if (neg) hi_n = add_s;
        state_n = S_DONE;
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State and datapath registers; busy/done are registered decodes of state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      a     <= '0;
      hi    <= '0;
      lo    <= '0;
      sgn   <= 1'b0;
      neg   <= 1'b0;
      negc  <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      a     <= a_n;
      hi    <= hi_n;
      lo    <= lo_n;
      sgn   <= sgn_n;
      neg   <= neg_n;
      negc  <= negc_n;
      cnt   <= cnt_n;
      busy  <= (state != S_IDLE);
      done  <= (state == S_DONE);
    end
  end

endmodule

// File: tb/tb_mult_sequencer.sv
// Scoreboard bench for mult_sequencer: stimulus pushes expected hi/lo and
// latency; a negedge monitor pops and compares on every done pulse.
module tb_mult_sequencer;

  localparam int unsigned W = 32;
  localparam int LAT_U = 33;
  localparam int LAT_S = 37;

  logic         clk;
  logic         rst;
  logic         start;
  logic         is_signed;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           k;
    int           n;
  } exp_t;

  exp_t q[$];
  int   cyc;
  int   checks;
  int   failures;

  mult_sequencer #(.DATA_LEN(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts rising edges; after edge k, cyc == k.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one start; start is sampled at the next edge k = cyc + 1.
  task automatic issue(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit push, input logic [W-1:0] eh, input logic [W-1:0] el);
    exp_t e;
    is_signed = sg;
    op_a      = a;
    op_b      = b;
    start     = 1'b1;
    if (push) begin
      e.hi = eh;
      e.lo = el;
      e.k  = cyc + 1;
      e.n  = sg ? LAT_S : LAT_U;
      q.push_back(e);
    end
    tick();
    start = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 80) begin
      tick();
      n++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", 64'(q.size()), 64'd0);
      q.delete();
    end
    tick();
    tick();
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", {hi, lo}, 64'd0);
        checks++;
        failures++;
        $display("FAIL spurious_done actual=1 expected=0 (cycle %0d)", cyc);
      end else begin
        e = q.pop_front();
        chk("hi", 64'(hi), 64'(e.hi));
        chk("lo", 64'(lo), 64'(e.lo));
        chk("latency", 64'(cyc - e.k), 64'(e.n));
      end
    end
  end

  initial begin
    int k;
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    op_a      = '0;
    op_b      = '0;

    // Reset, then idle with start low.
    tick();
    tick();
    chk("rst_state", {busy, done, hi, lo}, 66'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_hold", {busy, done, hi, lo}, 66'd0);
    end

    // MULTU max*max with busy window check.
    k = cyc + 1;
    issue(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 32'h00000001);
    for (int i = 1; i <= LAT_U + 1; i++) begin
      tick();
      chk("busy_window", 64'(busy), (cyc <= k + LAT_U) ? 64'd1 : 64'd0);
    end
    drain();

    // Signed cases.
    issue(1'b1, 32'hFFFFFFFD, 32'h00000005, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1);
    drain();
    issue(1'b1, 32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000);
    drain();
    issue(1'b1, 32'hFFFFFFF9, 32'h00000000, 1'b1, 32'h00000000, 32'h00000000);
    drain();
    issue(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h00000001);
    drain();
    issue(1'b0, 32'h80000000, 32'h00000003, 1'b1, 32'h00000001, 32'h80000000);
    drain();

    // Starts while busy (mid-run and in the done cycle) are ignored.
    k = cyc + 1;
    issue(1'b0, 32'h00001234, 32'h00000100, 1'b1, 32'h00000000, 32'h00123400);
    while (cyc < k + 4) tick();
    is_signed = 1'b1;
    op_a      = 32'h7;
    op_b      = 32'h9;
    start     = 1'b1;
    tick();
    start = 1'b0;
    while (cyc < k + LAT_U) tick();
    op_a  = 32'hABCD;
    op_b  = 32'h1111;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 45; i++) tick();
    chk("ignored_start_busy", 64'(busy), 64'd0);
    chk("ignored_start_result", {hi, lo}, 64'h0000000000123400);
    chk("ignored_start_queue", 64'(q.size()), 64'd0);

    // Reset mid-operation, then a clean product.
    k = cyc + 1;
    issue(1'b0, 32'hDEADBEEF, 32'h0000FFFF, 1'b0, '0, '0);
    while (cyc < k + 9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_state", {busy, done, hi, lo}, 66'd0);
    for (int i = 0; i < 40; i++) tick();
    chk("midrst_quiet", {busy, hi, lo}, 65'd0);
    issue(1'b0, 32'h12345678, 32'h00000010, 1'b1, 32'h00000001, 32'h23456780);
    drain();
    chk("final_hold", {hi, lo}, 64'h0000000123456780);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
